riscv_lsu: RTL and testbench

Load/store unit between the multi-cycle RISC-V core's memory-access stage and the word-wide data RAM. Accepts one load or store per handshake, using RV32I funct3 encoding. Generates per-byte write strobes and lane-replicated store data. Returns sign- or zero-extended load data, or an error for misaligned or illegal accesses. Resolves the core's byte/halfword access handling in one dedicated block.

---
 rtl/riscv_lsu.sv | 173 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: byte/half/word access to a word-wide synchronous RAM.
// Optional macro LSU_BOUNDS_CHECK_EN rejects addresses beyond the RAM size.
module riscv_lsu #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state_reg, state_next;
  logic                  we_reg, we_next;
  logic [2:0]            f3_reg, f3_next;
  logic [1:0]            lane_reg, lane_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [3:0]            mem_we_reg, mem_we_next;
  logic [31:0]           mem_wdata_reg, mem_wdata_next;
  logic [31:0]           resp_rdata_reg, resp_rdata_next;
  logic                  resp_err_reg, resp_err_next;

  logic        legal, misaligned, out_of_range, bad_req;
  logic [3:0]  strobe;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = |req_addr[31:ADDR_WIDTH+2];
`else
  // Upper address bits are dropped, so accesses alias into the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];
  assign out_of_range   = 1'b0;
`endif

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    strobe     = 4'b1111;
    wdata_rep  = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        strobe    = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        strobe     = 4'b0011 << req_addr[1:0];
        wdata_rep  = {2{req_wdata[15:0]}};
      end
      default: misaligned = |req_addr[1:0];
    endcase
    bad_req = !legal || misaligned || out_of_range;
  end

  // Little-endian lane extraction and extension of the RAM word.
  always_comb begin
    ld_byte = mem_rdata[8*lane_reg +: 8];
    ld_half = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_reg)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    we_next         = we_reg;
    f3_next         = f3_reg;
    lane_next       = lane_reg;
    mem_addr_next   = mem_addr_reg;
    mem_we_next     = 4'b0000;
    mem_wdata_next  = mem_wdata_reg;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          we_next   = req_we;
          f3_next   = req_funct3;
          lane_next = req_addr[1:0];
          if (bad_req) begin
            state_next      = RESP;
            resp_err_next   = 1'b1;
            resp_rdata_next = 32'd0;
          end else begin
            state_next    = ACCESS;
            mem_addr_next = req_addr[ADDR_WIDTH+1:2];
            if (req_we) begin
              mem_we_next    = strobe;
              mem_wdata_next = wdata_rep;
            end
          end
        end
      end
      ACCESS: begin
        if (we_reg) begin
          state_next      = RESP;
          resp_err_next   = 1'b0;
          resp_rdata_next = 32'd0;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        state_next      = RESP;
        resp_err_next   = 1'b0;
        resp_rdata_next = ld_ext;
      end
      default: begin
        state_next      = IDLE;
        resp_err_next   = 1'b0;
        resp_rdata_next = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      f3_reg         <= 3'd0;
      lane_reg       <= 2'd0;
      mem_addr_reg   <= '0;
      mem_we_reg     <= 4'b0000;
      mem_wdata_reg  <= 32'd0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      we_reg         <= we_next;
      f3_reg         <= f3_next;
      lane_reg       <= lane_next;
      mem_addr_reg   <= mem_addr_next;
      mem_we_reg     <= mem_we_next;
      mem_wdata_reg  <= mem_wdata_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
    end
  end

  assign req_ready  = (state_reg == IDLE) && !rst;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_we     = mem_we_reg;
  assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a synchronous byte-writable RAM model.
// Expected values follow LSU_BOUNDS_CHECK_EN when the macro is defined.
module tb_riscv_lsu;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] ram [0:(1<<AW)-1];

  int total  = 0;
  int passed = 0;

  riscv_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_we[k]) ram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request; fields are scrambled after acceptance to prove they were captured.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_we, input logic [31:0] exp_maddr,
                        input logic [31:0] exp_mwdata);
    int lat, we_cycles, exp_lat;
    logic [3:0]  we_seen;
    logic [31:0] addr0, wdata0;
    exp_lat = exp_err ? 0 : (we ? 1 : 2);
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b011;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    lat = 0; we_cycles = 0; we_seen = 4'b0000;
    addr0 = {22'd0, mem_addr}; wdata0 = mem_wdata;
    while (!resp_valid && lat < 8) begin
      if (mem_we != 4'b0000) we_cycles++;
      we_seen |= mem_we;
      @(posedge clk); #1;
      lat++;
    end
    if (mem_we != 4'b0000) we_cycles++;
    we_seen |= mem_we;
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".we"}, {28'd0, we_seen}, {28'd0, exp_we});
    check({tag, ".we_cycles"}, we_cycles, (exp_we != 4'b0000) ? 1 : 0);
    if (!exp_err) check({tag, ".maddr"}, addr0, exp_maddr);
    if (we && !exp_err) check({tag, ".mwdata"}, wdata0, exp_mwdata);
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
    $display("%s: we=%0b f3=%03b addr=%h rdata=%h err=%0b lat=%0d",
             tag, we, f3, addr, resp_rdata, resp_err, lat);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = 32'd0;
    ram[0] = 32'hCAFE_F00D;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", {31'd0, req_ready}, 32'd0);
    check("rst.valid", {31'd0, resp_valid}, 32'd0);
    check("rst.err", {31'd0, resp_err}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.we", {28'd0, mem_we}, 32'd0);
    check("rst.maddr", {22'd0, mem_addr}, 32'd0);
    check("rst.mwdata", mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst.ready_after", {31'd0, req_ready}, 32'd1);

    do_req("sw_10",   1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 32'h0,         4'b1111, 32'h4, 32'hDEAD_BEEF);
    do_req("lw_10",   0, 3'b010, 32'h10, 32'h0,         0, 32'hDEAD_BEEF, 4'b0000, 32'h4, 32'h0);
    do_req("sb_13",   1, 3'b000, 32'h13, 32'h1234_56A5, 0, 32'h0,         4'b1000, 32'h4, 32'hA5A5_A5A5);
    do_req("lb_13",   0, 3'b000, 32'h13, 32'h0,         0, 32'hFFFF_FFA5, 4'b0000, 32'h4, 32'h0);
    do_req("lbu_13",  0, 3'b100, 32'h13, 32'h0,         0, 32'h0000_00A5, 4'b0000, 32'h4, 32'h0);
    do_req("lbu_11",  0, 3'b100, 32'h11, 32'h0,         0, 32'h0000_00BE, 4'b0000, 32'h4, 32'h0);
    do_req("sw_10b",  1, 3'b010, 32'h10, 32'h8001_7FFF, 0, 32'h0,         4'b1111, 32'h4, 32'h8001_7FFF);
    do_req("lh_12",   0, 3'b001, 32'h12, 32'h0,         0, 32'hFFFF_8001, 4'b0000, 32'h4, 32'h0);
    do_req("lhu_12",  0, 3'b101, 32'h12, 32'h0,         0, 32'h0000_8001, 4'b0000, 32'h4, 32'h0);
    do_req("lh_10",   0, 3'b001, 32'h10, 32'h0,         0, 32'h0000_7FFF, 4'b0000, 32'h4, 32'h0);
    do_req("sh_12",   1, 3'b001, 32'h12, 32'h1111_BEEF, 0, 32'h0,         4'b1100, 32'h4, 32'hBEEF_BEEF);
    do_req("lw_10c",  0, 3'b010, 32'h10, 32'h0,         0, 32'hBEEF_7FFF, 4'b0000, 32'h4, 32'h0);
    do_req("lw_mis",  0, 3'b010, 32'h06, 32'h0,         1, 32'h0,         4'b0000, 32'h0, 32'h0);
    do_req("sh_mis",  1, 3'b001, 32'h01, 32'hFFFF,      1, 32'h0,         4'b0000, 32'h0, 32'h0);
    do_req("ld_f011", 0, 3'b011, 32'h10, 32'h0,         1, 32'h0,         4'b0000, 32'h0, 32'h0);
    do_req("st_f100", 1, 3'b100, 32'h10, 32'h1234,      1, 32'h0,         4'b0000, 32'h0, 32'h0);

    // Reset while a load sits in WAIT: the response must never appear.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("rstw.ready_low", {31'd0, req_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rstw.no_resp", {31'd0, resp_valid}, 32'd0);
      check("rstw.we", {28'd0, mem_we}, 32'd0);
    end
    rst = 1'b0; #1;
    check("rstw.ready_high", {31'd0, req_ready}, 32'd1);
    $display("rst_in_wait: resp suppressed, ready=%0b", req_ready);
    do_req("lw_after", 0, 3'b010, 32'h10, 32'h0, 0, 32'hBEEF_7FFF, 4'b0000, 32'h4, 32'h0);

`ifdef LSU_BOUNDS_CHECK_EN
    do_req("lw_1000", 0, 3'b010, 32'h1000, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 32'h0);
`else
    do_req("lw_1000", 0, 3'b010, 32'h1000, 32'h0, 0, 32'hCAFE_F00D, 4'b0000, 32'h0, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
